// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Multi-channel pushbutton front end. Each channel goes through
//                a 2-flop synchroniser, a saturating debounce counter and an
//                auto-repeat state machine that emits one-cycle press pulses
//                (initial press plus auto-repeats) and release pulses.
//  Ports       : clk_in         - system clock
//                rst_n_in       - synchronous active-low reset
//                noisy_in       - raw asynchronous button levels (active high)
//                repeat_en_in   - per-channel auto-repeat enable
//                clean_out      - debounced level
//                press_out      - one-cycle press / auto-repeat pulse
//                release_out    - one-cycle release pulse
//                any_press_out  - OR of press_out
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int CHANNELS      = 5,
    parameter int DB_COUNT      = 1_000_000,
    parameter int REPEAT_DELAY  = 32_500_000,
    parameter int REPEAT_PERIOD = 6_500_000
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [CHANNELS-1:0] noisy_in,
    input  logic [CHANNELS-1:0] repeat_en_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] press_out,
    output logic [CHANNELS-1:0] release_out,
    output logic                any_press_out
);

    localparam int c_DB_W      = $clog2(DB_COUNT + 1);
    localparam int c_RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W     = $clog2(c_RPT_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(DB_COUNT - 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HELD   = 2'd1;
    localparam logic [1:0] c_ST_DELAY  = 2'd2;
    localparam logic [1:0] c_ST_REPEAT = 2'd3;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_chan
            logic               r_s1;
            logic               r_s2;
            logic               r_clean;
            logic [c_DB_W-1:0]  r_db_cnt;
            logic               w_differ;
            logic               w_toggle;
            logic               w_rise;
            logic               w_fall;

            logic [1:0]         r_state;
            logic [1:0]         w_state_nxt;
            logic [c_RPT_W-1:0] r_rpt_cnt;
            logic [c_RPT_W-1:0] w_rpt_cnt_nxt;
            logic               r_press;
            logic               w_press_nxt;
            logic               r_release;
            logic               w_release_nxt;

            // The debounced level flips on the DB_COUNT-th consecutive
            // differing cycle; the FSM reacts to that same edge so the
            // pulses line up with the first cycle clean_out shows the change.
            assign w_differ = (r_s2 != r_clean);
            assign w_toggle = w_differ && (r_db_cnt == c_DB_LAST);
            assign w_rise   = w_toggle && !r_clean;
            assign w_fall   = w_toggle &&  r_clean;

            always_ff @(posedge clk_in) begin
                if (!rst_n_in) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_clean  <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_s1 <= noisy_in[g];
                    r_s2 <= r_s1;
                    if (w_toggle) begin
                        r_clean  <= ~r_clean;
                        r_db_cnt <= '0;
                    end else if (w_differ) begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end else begin
                        r_db_cnt <= '0;
                    end
                end
            end

            always_ff @(posedge clk_in) begin
                if (!rst_n_in) begin
                    r_state   <= c_ST_IDLE;
                    r_rpt_cnt <= '0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_rpt_cnt <= w_rpt_cnt_nxt;
                    r_press   <= w_press_nxt;
                    r_release <= w_release_nxt;
                end
            end

            always_comb begin
                w_state_nxt   = r_state;
                w_rpt_cnt_nxt = r_rpt_cnt;
                w_press_nxt   = 1'b0;
                w_release_nxt = 1'b0;
                if (w_fall) begin
                    // Release wins over any repeat pulse due this cycle.
                    w_release_nxt = 1'b1;
                    w_state_nxt   = c_ST_IDLE;
                    w_rpt_cnt_nxt = '0;
                end else begin
                    case (r_state)
                        c_ST_IDLE: begin
                            if (w_rise) begin
                                w_press_nxt   = 1'b1;
                                w_rpt_cnt_nxt = '0;
                                w_state_nxt   = repeat_en_in[g] ? c_ST_DELAY : c_ST_HELD;
                            end
                        end
                        c_ST_HELD: begin
                            if (repeat_en_in[g]) begin
                                w_state_nxt   = c_ST_DELAY;
                                w_rpt_cnt_nxt = '0;
                            end
                        end
                        c_ST_DELAY: begin
                            if (!repeat_en_in[g]) begin
                                w_state_nxt   = c_ST_HELD;
                                w_rpt_cnt_nxt = '0;
                            end else if (r_rpt_cnt == c_DELAY_LAST) begin
                                w_press_nxt   = 1'b1;
                                w_rpt_cnt_nxt = '0;
                                w_state_nxt   = c_ST_REPEAT;
                            end else begin
                                w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                            end
                        end
                        default: begin
                            if (!repeat_en_in[g]) begin
                                w_state_nxt   = c_ST_HELD;
                                w_rpt_cnt_nxt = '0;
                            end else if (r_rpt_cnt == c_PERIOD_LAST) begin
                                w_press_nxt   = 1'b1;
                                w_rpt_cnt_nxt = '0;
                            end else begin
                                w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                            end
                        end
                    endcase
                end
            end

            assign clean_out[g]   = r_clean;
            assign press_out[g]   = r_press;
            assign release_out[g] = r_release;
        end
    endgenerate

    assign any_press_out = |press_out;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed bench for button_conditioner (2 channels, short
//                timing). Expected pulses are queued with their absolute edge
//                number when stimulus is driven and checked as edges occur.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_CH = 2;

    logic            clk_in;
    logic            rst_n_in;
    logic [c_CH-1:0] noisy_in;
    logic [c_CH-1:0] repeat_en_in;
    logic [c_CH-1:0] clean_out;
    logic [c_CH-1:0] press_out;
    logic [c_CH-1:0] release_out;
    logic            any_press_out;

    button_conditioner #(
        .CHANNELS      (c_CH),
        .DB_COUNT      (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .noisy_in      (noisy_in),
        .repeat_en_in  (repeat_en_in),
        .clean_out     (clean_out),
        .press_out     (press_out),
        .release_out   (release_out),
        .any_press_out (any_press_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // kind: 0 press edge (clean rises), 1 repeat press, 2 release (clean
    // falls), 3 reset (clean cleared, no pulse)
    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    ev_t             q[$];
    int              cyc = 0;
    int              n_tests = 0;
    int              n_fail = 0;
    logic [c_CH-1:0] exp_clean = '0;

    task automatic push(input int c, input int ch, input int kind);
        q.push_back('{c, ch, kind});
    endtask

    task automatic check();
        logic [c_CH-1:0] ep;
        logic [c_CH-1:0] er;
        ep = '0;
        er = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                case (q[i].kind)
                    0: begin ep[q[i].ch] = 1'b1; exp_clean[q[i].ch] = 1'b1; end
                    1: ep[q[i].ch] = 1'b1;
                    2: begin er[q[i].ch] = 1'b1; exp_clean[q[i].ch] = 1'b0; end
                    default: exp_clean[q[i].ch] = 1'b0;
                endcase
                q.delete(i);
            end
        end
        n_tests++;
        assert (press_out === ep) else begin
            n_fail++;
            $error("FAIL press edge=%0d observed=%b expected=%b", cyc, press_out, ep);
        end
        n_tests++;
        assert (release_out === er) else begin
            n_fail++;
            $error("FAIL release edge=%0d observed=%b expected=%b", cyc, release_out, er);
        end
        n_tests++;
        assert (clean_out === exp_clean) else begin
            n_fail++;
            $error("FAIL clean edge=%0d observed=%b expected=%b", cyc, clean_out, exp_clean);
        end
        n_tests++;
        assert (any_press_out === (|ep)) else begin
            n_fail++;
            $error("FAIL any_press edge=%0d observed=%b expected=%b", cyc, any_press_out, |ep);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        cyc++;
        #1;
        check();
    endtask

    // Inputs changed after run_to(c) are first sampled at edge c+1.
    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        int n;
        int e;
        rst_n_in     = 1'b0;
        noisy_in     = 2'b11;
        repeat_en_in = 2'b00;

        // Reset with both buttons held; fresh press after release of reset
        run_to(3);
        rst_n_in = 1'b1;                 // first normal edge k = 4
        push(9, 0, 0);
        push(9, 1, 0);
        run_to(12);
        noisy_in = 2'b00;
        push(18, 0, 2);
        push(18, 1, 2);
        run_to(22);

        // Glitch of 3 synchronised cycles is discarded
        noisy_in[0] = 1'b1;
        run_to(25);
        noisy_in[0] = 1'b0;
        run_to(35);

        // Exactly DB_COUNT stable cycles is accepted
        n = cyc;
        noisy_in[0] = 1'b1;
        push(n + 6, 0, 0);
        run_to(n + 4);
        noisy_in[0] = 1'b0;
        push(n + 10, 0, 2);
        run_to(n + 16);

        // Auto-repeat held 30 cycles past press edge
        n = cyc;
        e = n + 6;
        noisy_in[0]     = 1'b1;
        repeat_en_in[0] = 1'b1;
        push(e, 0, 0);
        for (int i = 0; i < 7; i++) push(e + 10 + 3 * i, 0, 1);
        run_to(e + 24);
        noisy_in[0] = 1'b0;
        push(e + 30, 0, 2);
        run_to(e + 36);

        // Repeat disabled mid-hold, then re-enabled (full delay restart)
        n = cyc;
        e = n + 6;
        noisy_in[0] = 1'b1;
        push(e, 0, 0);
        push(e + 10, 0, 1);
        run_to(e + 11);
        repeat_en_in[0] = 1'b0;
        run_to(e + 19);
        repeat_en_in[0] = 1'b1;
        push(e + 30, 0, 1);
        push(e + 33, 0, 1);
        run_to(e + 29);
        noisy_in[0] = 1'b0;
        push(e + 35, 0, 2);
        run_to(e + 41);

        // Release lands on a repeat boundary: only release pulses
        n = cyc;
        e = n + 6;
        noisy_in[0] = 1'b1;
        push(e, 0, 0);
        push(e + 10, 0, 1);
        push(e + 13, 0, 1);
        run_to(e + 10);
        noisy_in[0] = 1'b0;
        push(e + 16, 0, 2);
        run_to(e + 24);

        // Reset mid-repeat aborts with no pulse
        n = cyc;
        e = n + 6;
        noisy_in[0] = 1'b1;
        push(e, 0, 0);
        push(e + 10, 0, 1);
        run_to(e + 10);
        rst_n_in    = 1'b0;
        noisy_in[0] = 1'b0;
        push(e + 11, 0, 3);
        run_to(e + 14);
        rst_n_in = 1'b1;
        run_to(e + 25);

        // Independent channels offset by 2 cycles
        n = cyc;
        e = n + 6;
        repeat_en_in = 2'b11;
        noisy_in[0]  = 1'b1;
        push(e, 0, 0);
        for (int i = 0; i < 4; i++) push(e + 10 + 3 * i, 0, 1);
        push(e + 20, 0, 2);
        push(e + 2, 1, 0);
        for (int i = 0; i < 4; i++) push(e + 12 + 3 * i, 1, 1);
        push(e + 22, 1, 2);
        run_to(n + 2);
        noisy_in[1] = 1'b1;
        run_to(e + 14);
        noisy_in[0] = 1'b0;
        run_to(e + 16);
        noisy_in[1] = 1'b0;
        run_to(e + 28);

        n_tests++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL pending_events observed=%0d expected=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
